// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants.
// The transmitter imports the same package so both ends agree on framing.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int   DEF_CLKS_PER_BIT = 104;
  localparam int   DATA_BITS        = 8;
  localparam logic STOP_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// N-flop synchroniser for asynchronous single-bit inputs, with a selectable
// reset value so idle-high lines do not read as activity after reset.
module sync_ff #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {N{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rx line, delivering
// each byte through a valid/ack holding register with framing/overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  // Preset high so a reset never looks like a start bit.
  sync_ff #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s == STOP_LEVEL) begin
            state_d    = ST_IDLE;
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ack;
          end else begin
            state_d     = ST_BREAK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Every bit is rewritten before use, so the shifter needs no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of 8N1 frames plus hand-written corner sequences,
// with a byte scoreboard checked whenever the receiver completes a frame.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int cyc = 0;
  int ack_cyc = -1;
  bit auto_ack = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters, scoreboard pop on each completion, ack driver.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((rx_valid && !prev_valid) || overrun) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
      end
    end
    prev_valid = rx_valid;
    rx_ack = (auto_ack && rx_valid && !rx_ack) || (cyc == ack_cyc);
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int fe0;
    int ov0;
    int c0;
    logic [7:0] last_good;
    logic [7:0] d5a;

    vecs[0] = '{8'h00, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 1'b1};
    vecs[3] = '{8'h96, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1};
    vecs[5] = '{8'hC3, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte with latency measurement
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (rx_valid) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("latency", lat, 155);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_busy", {31'd0, busy}, 32'd0);
    check("a5_frame_err", fe_cnt, 0);
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("a5_acked", {31'd0, rx_valid}, 32'd0);

    // Table: back-to-back frames, zero idle, auto ack
    last_good = 8'hA5;
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_valid) begin
        exp_q.push_back(vecs[v].data);
        last_good = vecs[v].data;
      end
      send_frame(vecs[v].data, vecs[v].stop);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_overrun", ov_cnt, 0);
    check("b2b_frame_err", fe_cnt, 0);

    // Glitch shorter than half a bit
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_frame_err", fe_cnt, 0);

    // Framing error followed by a held break
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_one_frame_err", fe_cnt - fe0, 1);
    check("break_data_held", {24'd0, rx_data}, {24'd0, last_good});
    check("break_no_valid", {31'd0, rx_valid}, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    check("after_break_data", {24'd0, rx_data}, 32'h42);

    // Overrun: two frames without ack
    auto_ack = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("overrun_pulses", ov_cnt - ov0, 1);
    check("overrun_data", {24'd0, rx_data}, 32'h22);
    check("overrun_valid", {31'd0, rx_valid}, 32'd1);
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);
    auto_ack = 1'b0;
    check("overrun_acked", {31'd0, rx_valid}, 32'd0);

    // Ack coinciding with completion: no overrun, new byte stays valid
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    ov0 = ov_cnt;
    c0 = cyc;
    ack_cyc = c0 + 154;
    send_frame(8'h33, 1'b1);
    repeat (3) @(negedge clk);
    ack_cyc = -1;
    check("coinc_overrun", ov_cnt - ov0, 0);
    check("coinc_valid", {31'd0, rx_valid}, 32'd1);
    check("coinc_data", {24'd0, rx_data}, 32'h33);
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during bit 3
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    d5a = 8'h5A;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d5a[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d5a[3];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    rx = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check("midreset_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset_data", {24'd0, rx_data}, 32'h00);
    check("midreset_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    check("midreset_second_data", {24'd0, rx_data}, 32'h5A);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of the top-level `tx` serial output. Deserialises 8N1 frames (idle high, start 0, 8 data bits LSB first, stop 1) from an asynchronous `rx` pin. Presents each byte on a valid/ack holding register. Sits beside the transmitter in top; used for loopback testing (tx→rx) and for host commands.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); must be ≥ 4. Bench uses 16.
- SYNC_STAGES, 2, depth of the input synchroniser flop chain (≥ 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idles high.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  level; high while rx_data holds an unacknowledged byte.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- frame_err  out  1  1-cycle pulse: stop bit sampled 0.
- overrun  out  1  1-cycle pulse: new byte completed while rx_valid=1 and rx_ack=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - rx_data=0x00; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - State=IDLE; counters=0; synchroniser flops preset to 1.
- rx passes through SYNC_STAGES flops, giving rx_s. All decisions use rx_s only.
- cnt: bit timer, width clog2(CLKS_PER_BIT). idx: 3-bit data index. sh: 8-bit shift register.
- States:
  - IDLE: when rx_s==0 → START, cnt=0.
  - START: cnt++ each cycle. At cnt==CLKS_PER_BIT/2−1: if rx_s==0 → DATA, cnt=0, idx=0. If rx_s==1, treat as a glitch → IDLE with no flags.
  - DATA: cnt++. At cnt==CLKS_PER_BIT−1: sh[idx]=rx_s, cnt=0, idx++. After idx==7 is sampled → STOP.
  - STOP: cnt++. At cnt==CLKS_PER_BIT−1:
    - rx_s==1: rx_data<=sh next cycle and rx_valid<=1 → IDLE.
    - rx_s==0: frame_err pulses, rx_data/rx_valid unchanged → BREAK.
  - BREAK: wait for rx_s==1 → IDLE. A held-low line yields exactly one frame_err.
- Sampling and latency:
  - All samples land at mid-bit (start + half period + n·CLKS_PER_BIT).
  - Returning to IDLE at mid-stop allows back-to-back frames with zero idle time.
  - rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the rx falling edge of the start bit. With the defaults and CLKS_PER_BIT=16: 155 cycles.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - rx_data holds until the next good frame.
- Simultaneous events:
  - Completion while rx_valid=1 and rx_ack=0: overrun pulses, rx_data overwritten, rx_valid stays 1.
  - Completion in the same cycle as rx_ack: rx_valid stays 1 with the new byte, no overrun.
- Reset mid-frame: immediate return to IDLE. The partial byte is discarded; no flags pulse.
- Framing: no parity; break is detected only as frame_err. No baud auto-detect.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE, START, DATA, STOP, BREAK), 3 bits;
  - default CLKS_PER_BIT;
  - frame constants DATA_BITS=8, STOP_LEVEL=1.
- The transmitter shares this include.
- One natural sub-module: sync_ff (parameterised N-flop synchroniser with reset value), reused for the switch inputs.
- FSM, bit timer and shift register stay flat in uart_rx.

Test Plan:
- Single byte: drive 0xA5 8N1 at CLKS_PER_BIT=16 → rx_valid rises 155 cycles after the start edge; rx_data=0xA5; frame_err=0; busy low afterwards.
- Back-to-back 0x00, 0xFF, 0x3C, no idle gap, rx_ack pulsed after each valid → three valids with matching rx_data; no overrun; no frame_err.
- Glitch: rx low for 4 cycles then high → stays in IDLE after START abort; no rx_valid; no frame_err; busy high for ≤ 8+SYNC_STAGES cycles.
- Framing/break: send 0x81 with stop=0, then hold rx low for 200 cycles, then release → exactly one frame_err pulse; rx_data unchanged; the next good 0x42 is received correctly.
- Overrun: send 0x11 then 0x22 without rx_ack → one overrun pulse at the second completion; rx_data=0x22; rx_valid=1. Repeat with rx_ack coinciding with completion → no overrun.
- Reset mid-frame: assert reset during bit 3 of 0x5A, release, send 0x5A again → no valid or flags from the first frame; second frame yields rx_data=0x5A.
- Loopback: connect top tx to rx → received bytes equal transmitted bytes.
